// File: rtl/pair_stream_pkg.sv
// Shared constants for the paired-stream aligner.
// State encoding and default widths live here.
package pair_stream_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_PASS   = 2'd0;
  localparam state_t S_DRAIN0 = 2'd1;
  localparam state_t S_DRAIN1 = 2'd2;

endpackage

// File: rtl/pair_stream_aligner.sv
// Joins two AXI-Stream lanes into one paired stream.
// Mismatched packet ends truncate and drain the longer lane.
module pair_stream_aligner
  import pair_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i0_tdata,
  input  logic             i0_tlast,
  input  logic             i0_tvalid,
  output logic             i0_tready,
  input  logic [WIDTH-1:0] i1_tdata,
  input  logic             i1_tlast,
  input  logic             i1_tvalid,
  output logic             i1_tready,
  output logic [WIDTH-1:0] o0_tdata,
  output logic [WIDTH-1:0] o1_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             err_stb,
  output logic [CNT_W-1:0] err_count
);

  state_t           state_q, state_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] d0_q, d0_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic             stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic slot_acc;
  logic both_vld;
  logic pass_fire;
  logic mismatch;

  assign slot_acc = !vld_q || o_tready;
  assign both_vld = i0_tvalid && i1_tvalid;
  assign mismatch = i0_tlast ^ i1_tlast;
  assign pass_fire = (state_q == S_PASS) && both_vld
                     && slot_acc && !clear && !reset;

  // Lane readiness: joint in pass, single lane while draining
  always_comb begin
    i0_tready = 1'b0;
    i1_tready = 1'b0;
    if (!reset && !clear) begin
      case (state_q)
        S_PASS: begin
          i0_tready = both_vld && slot_acc;
          i1_tready = both_vld && slot_acc;
        end
        S_DRAIN0: i0_tready = 1'b1;
        S_DRAIN1: i1_tready = 1'b1;
        default: ;
      endcase
    end
  end

  // Next state for FSM, output slot and error tracking
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    last_d  = last_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    stb_d   = 1'b0;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = S_PASS;
      vld_d   = 1'b0;
    end else begin
      if (pass_fire) begin
        vld_d  = 1'b1;
        d0_d   = i0_tdata;
        d1_d   = i1_tdata;
        last_d = i0_tlast | i1_tlast;
      end else if (o_tready) begin
        vld_d = 1'b0;
      end
      case (state_q)
        S_PASS: begin
          if (pass_fire && mismatch) begin
            stb_d = 1'b1;
            if (cnt_q != '1)
              cnt_d = cnt_q + CNT_W'(1);
            state_d = i0_tlast ? S_DRAIN1 : S_DRAIN0;
          end
        end
        S_DRAIN0: begin
          if (i0_tvalid && i0_tlast)
            state_d = S_PASS;
        end
        S_DRAIN1: begin
          if (i1_tvalid && i1_tlast)
            state_d = S_PASS;
        end
        default: state_d = S_PASS;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_PASS;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o0_tdata  = d0_q;
  assign o1_tdata  = d1_q;
  assign o_tlast   = last_q;
  assign o_tvalid  = vld_q;
  assign err_stb   = stb_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_pair_stream_aligner.sv
// Directed bench for pair_stream_aligner.
// Lane queues feed the DUT; outputs are collected and checked.
module tb_pair_stream_aligner;

  localparam int W  = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [W-1:0]  i0_tdata, i1_tdata;
  logic          i0_tlast, i1_tlast;
  logic          i0_tvalid, i1_tvalid;
  logic          i0_tready, i1_tready;
  logic [W-1:0]  o0_tdata, o1_tdata;
  logic          o_tlast, o_tvalid, o_tready;
  logic          err_stb;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  pair_stream_aligner #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i0_tdata(i0_tdata), .i0_tlast(i0_tlast),
    .i0_tvalid(i0_tvalid), .i0_tready(i0_tready),
    .i1_tdata(i1_tdata), .i1_tlast(i1_tlast),
    .i1_tvalid(i1_tvalid), .i1_tready(i1_tready),
    .o0_tdata(o0_tdata), .o1_tdata(o1_tdata),
    .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .err_stb(err_stb), .err_count(err_count)
  );

  typedef struct packed {
    logic         last;
    logic [W-1:0] d;
  } beat_t;

  typedef struct packed {
    logic         last;
    logic [W-1:0] d1;
    logic [W-1:0] d0;
  } pair_t;

  beat_t l0[$];
  beat_t l1[$];
  pair_t outs[$];
  logic  en0 = 1'b1;
  logic  en1 = 1'b1;
  logic  r0, r1;
  int    pulses = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always @(posedge clk) begin
    if (o_tvalid && o_tready)
      outs.push_back({o_tlast, o1_tdata, o0_tdata});
    if (err_stb)
      pulses <= pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic put(int lane, int d, logic last);
    beat_t b;
    b.last = last;
    b.d    = W'(d);
    if (lane == 0) l0.push_back(b);
    else           l1.push_back(b);
  endtask

  task automatic pkt4(int b0, int b1);
    for (int i = 1; i <= 4; i++) begin
      put(0, b0 * i, i == 4);
      put(1, b1 * i, i == 4);
    end
  endtask

  // One clock: present queue heads, record handshakes, pop on accept
  task automatic cyc();
    i0_tvalid = en0 && (l0.size() > 0);
    i0_tdata  = (l0.size() > 0) ? l0[0].d : '0;
    i0_tlast  = (l0.size() > 0) && l0[0].last;
    i1_tvalid = en1 && (l1.size() > 0);
    i1_tdata  = (l1.size() > 0) ? l1[0].d : '0;
    i1_tlast  = (l1.size() > 0) && l1[0].last;
    #1;
    r0 = i0_tvalid && i0_tready;
    r1 = i1_tvalid && i1_tready;
    @(posedge clk);
    if (r0) void'(l0.pop_front());
    if (r1) void'(l1.pop_front());
    #1;
  endtask

  task automatic run_out(int lim);
    int n = 0;
    while ((l0.size() > 0 || l1.size() > 0) && n < lim) begin
      cyc();
      n++;
    end
    cyc();
    cyc();
    chk("run_out_left", l0.size() + l1.size(), 0);
  endtask

  task automatic chk_out(string tag, int i, int d0, int d1,
                         logic last);
    pair_t p = '0;
    if (i < outs.size()) p = outs[i];
    chk({tag, ".d0"}, p.d0, d0);
    chk({tag, ".d1"}, p.d1, d1);
    chk({tag, ".last"}, p.last, last);
  endtask

  task automatic chk_std4(string tag, int n0, int n1);
    chk({tag, ".n"}, outs.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_out(tag, i, n0 * (i + 1), n1 * (i + 1), i == 3);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    clear = 1'b0;
    o_tready = 1'b0;
    i0_tdata = '0; i1_tdata = '0;
    i0_tlast = 1'b0; i1_tlast = 1'b0;
    i0_tvalid = 1'b0; i1_tvalid = 1'b0;
    @(posedge clk);
    #1;

    // reset state, with beats offered
    put(0, 1, 1'b1);
    put(1, 10, 1'b1);
    cyc();
    cyc();
    chk("rst.rdy", {r0, r1}, 2'b00);
    chk("rst.vld", o_tvalid, 1'b0);
    chk("rst.last", o_tlast, 1'b0);
    chk("rst.d0", o0_tdata, 0);
    chk("rst.d1", o1_tdata, 0);
    chk("rst.stb", err_stb, 1'b0);
    chk("rst.cnt", err_count, 0);
    l0.delete();
    l1.delete();
    reset = 1'b0;
    o_tready = 1'b1;

    // aligned 4-beat packets
    outs.delete();
    pkt4(1, 10);
    cyc();
    chk("A.rdy", {r0, r1}, 2'b11);
    chk("A.lat", o_tvalid, 1'b1);
    run_out(20);
    chk_std4("A", 1, 10);
    chk("A.cnt", err_count, 0);

    // backpressure 1,0,0,1
    outs.delete();
    pkt4(5, 50);
    cyc();
    o_tready = 1'b0;
    cyc();
    chk("B.rdy1", {r0, r1}, 2'b00);
    chk("B.hold1", {o_tvalid, o0_tdata, o1_tdata},
        {1'b1, 32'd5, 32'd50});
    cyc();
    chk("B.rdy2", {r0, r1}, 2'b00);
    chk("B.hold2", {o_tvalid, o0_tdata, o1_tdata},
        {1'b1, 32'd5, 32'd50});
    o_tready = 1'b1;
    run_out(20);
    chk_std4("B", 5, 50);

    // lane 1 skewed by 3 cycles
    outs.delete();
    pkt4(1, 10);
    en1 = 1'b0;
    repeat (3) cyc();
    chk("C.rdy", r0, 1'b0);
    chk("C.vld", o_tvalid, 1'b0);
    en1 = 1'b1;
    cyc();
    chk("C.lat", o_tvalid, 1'b1);
    run_out(20);
    chk_std4("C", 1, 10);

    // short lane 0, then a clean packet
    outs.delete();
    p0 = pulses;
    put(0, 1, 1'b0); put(0, 2, 1'b1);
    put(0, 7, 1'b0); put(0, 8, 1'b1);
    for (int i = 1; i <= 5; i++) put(1, 10 * i, i == 5);
    put(1, 70, 1'b0); put(1, 80, 1'b1);
    cyc();
    cyc();
    chk("D.stb", err_stb, 1'b1);
    cyc();
    chk("D.drain_rdy", {r0, r1}, 2'b01);
    chk("D.stb_once", err_stb, 1'b0);
    run_out(20);
    chk("D.n", outs.size(), 4);
    chk_out("D0", 0, 1, 10, 1'b0);
    chk_out("D1", 1, 2, 20, 1'b1);
    chk_out("D2", 2, 7, 70, 1'b0);
    chk_out("D3", 3, 8, 80, 1'b1);
    chk("D.cnt", err_count, 1);
    chk("D.pulses", pulses - p0, 1);

    // clear during beat 2
    pkt4(1, 10);
    cyc();
    clear = 1'b1;
    o_tready = 1'b0;
    cyc();
    chk("E.clr_rdy", {r0, r1}, 2'b00);
    chk("E.flush", o_tvalid, 1'b0);
    clear = 1'b0;
    o_tready = 1'b1;
    l0.delete();
    l1.delete();

    // clear beats a pending mismatch
    put(0, 3, 1'b1);
    put(1, 30, 1'b0); put(1, 31, 1'b1);
    clear = 1'b1;
    cyc();
    chk("E.clr_rdy2", {r0, r1}, 2'b00);
    chk("E.nostb", err_stb, 1'b0);
    chk("E.cnt1", err_count, 1);
    clear = 1'b0;
    cyc();
    chk("E.stb", err_stb, 1'b1);
    chk("E.cnt2", err_count, 2);
    chk("E.trunc", {o0_tdata, o_tlast}, {32'd3, 1'b1});

    // clear mid-drain forces pass
    clear = 1'b1;
    cyc();
    chk("E.nodrain", r1, 1'b0);
    clear = 1'b0;
    l1.delete();
    put(0, 5, 1'b1);
    put(1, 50, 1'b1);
    cyc();
    chk("E.pass", {o_tvalid, o0_tdata, o1_tdata, o_tlast},
        {1'b1, 32'd5, 32'd50, 1'b1});
    chk("E.keep", err_count, 2);
    cyc();

    // three more mismatches, both directions; saturates at 3
    for (int k = 0; k < 3; k++) begin
      if (k % 2 == 0) begin
        put(0, 100 + k, 1'b1);
        put(1, 200 + k, 1'b0); put(1, 210 + k, 1'b1);
      end else begin
        put(0, 100 + k, 1'b0); put(0, 110 + k, 1'b1);
        put(1, 200 + k, 1'b1);
      end
      cyc();
      chk("S.stb", err_stb, 1'b1);
      chk("S.last", o_tlast, 1'b1);
      chk("S.cnt", err_count, 3);
      run_out(10);
      put(0, k + 1, 1'b1);
      put(1, k + 20, 1'b1);
      cyc();
      chk("S.next", {o_tvalid, o0_tdata, o1_tdata},
          {1'b1, 32'(k + 1), 32'(k + 20)});
      chk("S.nostb", err_stb, 1'b0);
      cyc();
    end

    // reset mid-drain abandons the packet
    put(0, 9, 1'b1);
    put(1, 90, 1'b0); put(1, 91, 1'b1);
    cyc();
    reset = 1'b1;
    cyc();
    chk("R.rdy", {r0, r1}, 2'b00);
    reset = 1'b0;
    l1.delete();
    put(0, 6, 1'b1);
    put(1, 60, 1'b1);
    cyc();
    chk("R.pair", {o_tvalid, o0_tdata, o1_tdata},
        {1'b1, 32'd6, 32'd60});
    chk("R.cnt", err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
